fetch_unit: RTL and testbench

Instruction fetch stage of the pipelined RV32 core. It owns the program counter and issues sequential requests to a fixed-latency instruction memory. Returned words go into a 2-entry instruction buffer that is handed to decode over a valid/ready handshake. The jump unit drives it through the redirect pair (`ctrlFetch`, `newPC`) and the issue stall (`halt`); on redirect it discards the buffer and the in-flight word and restarts at the target.

---
 rtl/fetch_unit.sv | 113 +++++++++++
 tb/tb_fetch_unit.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// RV32 instruction fetch stage: owns the PC and streams fixed-latency imem responses
// through a 2-entry buffer to decode, with redirect and squash of stale words.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ctrlFetch,
    input  logic [31:0] newPC,
    input  logic        halt,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready
);

    logic [31:0] fetch_pc_q, fetch_pc_d;
    logic [31:0] buf_instr_q [2];
    logic [31:0] buf_pc_q    [2];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;
    logic        inflight_q, inflight_d;
    logic [31:0] inflight_pc_q, inflight_pc_d;
    logic        squash_q, squash_d;

    logic        pop;
    logic        push;
    logic [2:0]  occupancy;

    always_comb begin
        instr_valid = (count_q != 2'd0) && !halt;
        pop         = instr_valid && instr_ready;
        // Buffered plus outstanding words, after this cycle's hand-off.
        occupancy   = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};
        imem_req    = !reset && (occupancy < 3'd2);
        imem_addr   = fetch_pc_q;
        instr       = (count_q != 2'd0) ? buf_instr_q[rd_ptr_q] : 32'h0;
        instr_pc    = (count_q != 2'd0) ? buf_pc_q[rd_ptr_q]    : 32'h0;
        // A response landing in a redirect cycle belongs to the old stream.
        push        = inflight_q && !squash_q && !ctrlFetch;
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        wr_ptr_d      = wr_ptr_q;
        rd_ptr_d      = rd_ptr_q;
        count_d       = count_q;
        inflight_d    = imem_req;
        inflight_pc_d = inflight_pc_q;
        squash_d      = squash_q;

        if (imem_req) begin
            fetch_pc_d    = fetch_pc_q + 32'd4;
            inflight_pc_d = fetch_pc_q;
        end
        if (inflight_q && squash_q) begin
            squash_d = 1'b0;
        end
        if (push) begin
            wr_ptr_d = ~wr_ptr_q;
        end
        if (pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 2'd1;
            2'b01:   count_d = count_q - 2'd1;
            default: count_d = count_q;
        endcase

        if (ctrlFetch) begin
            count_d    = 2'd0;
            wr_ptr_d   = 1'b0;
            rd_ptr_d   = 1'b0;
            fetch_pc_d = {newPC[31:2], 2'b00};
            // The request issued this cycle still returns next cycle and must be dropped.
            squash_d   = imem_req;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            wr_ptr_q      <= 1'b0;
            rd_ptr_q      <= 1'b0;
            count_q       <= 2'd0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= 32'h0;
            squash_q      <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            inflight_q    <= inflight_d;
            inflight_pc_q <= inflight_pc_d;
            squash_q      <= squash_d;
        end
    end

    // Storage is not reset; count gates every read of it.
    always_ff @(posedge clock) begin
        if (push && !reset) begin
            buf_instr_q[wr_ptr_q] <= imem_rdata;
            buf_pc_q[wr_ptr_q]    <= inflight_pc_q;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus random traffic against
// a queue-based reference model and an in-order delivery tracker.
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        ctrlFetch = 1'b0;
    logic [31:0] newPC = 32'h0;
    logic        halt = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;

    int n_checks = 0;
    int n_errors = 0;
    int n_pops   = 0;

    // Reference model state
    bit          m_known = 1'b0;
    logic [31:0] m_fetch_pc;
    bit          m_infl;
    logic [31:0] m_infl_pc;
    bit          m_squash;
    logic [31:0] m_buf [$];
    logic [31:0] exp_next;

    // Memory environment
    bit          prev_req = 1'b0;
    logic [31:0] prev_addr = 32'h0;

    always #5 clock = ~clock;

    fetch_unit #(.RESET_PC(RESET_PC)) dut (
        .clock       (clock),
        .reset       (reset),
        .ctrlFetch   (ctrlFetch),
        .newPC       (newPC),
        .halt        (halt),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready)
    );

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hA5A5_0000;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %08h expected %08h at %0t", tag, obs, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs after the falling edge, check, then advance the model.
    task automatic step(input bit rst, input bit cf, input logic [31:0] npc, input bit h,
                        input bit rdy);
        bit          e_valid;
        bit          e_pop;
        bit          e_req;
        logic [31:0] e_pc;
        logic [31:0] e_instr;
        int          occ;
        @(negedge clock);
        reset       = rst;
        ctrlFetch   = cf;
        newPC       = npc;
        halt        = h;
        instr_ready = rdy;
        imem_rdata  = prev_req ? mem_word(prev_addr) : $urandom;
        #1;
        e_pop = 1'b0;
        e_req = 1'b0;
        if (m_known) begin
            e_valid = (m_buf.size() != 0) && !h;
            e_pop   = e_valid && rdy;
            e_pc    = (m_buf.size() != 0) ? m_buf[0] : 32'h0;
            e_instr = (m_buf.size() != 0) ? mem_word(m_buf[0]) : 32'h0;
            occ     = m_buf.size() + int'(m_infl) - int'(e_pop);
            e_req   = !rst && (occ < 2);
            check_eq("instr_valid", 32'(instr_valid), 32'(e_valid));
            check_eq("imem_req", 32'(imem_req), 32'(e_req));
            if (e_req) check_eq("imem_addr", imem_addr, m_fetch_pc);
            check_eq("instr_pc", instr_pc, e_pc);
            check_eq("instr", instr, e_instr);
            if (instr_valid && rdy) begin
                check_eq("order", instr_pc, exp_next);
                exp_next = exp_next + 32'd4;
                n_pops++;
            end
        end
        prev_req  = imem_req;
        prev_addr = imem_addr;

        if (rst) begin
            m_buf.delete();
            m_fetch_pc = RESET_PC;
            m_infl     = 1'b0;
            m_infl_pc  = 32'h0;
            m_squash   = 1'b0;
            exp_next   = RESET_PC;
            m_known    = 1'b1;
        end else if (m_known) begin
            if (cf) begin
                m_buf.delete();
                m_squash   = e_req;
                if (e_req) m_infl_pc = m_fetch_pc;
                m_infl     = e_req;
                m_fetch_pc = npc & ~32'h3;
                exp_next   = npc & ~32'h3;
            end else begin
                if (e_pop) void'(m_buf.pop_front());
                if (m_infl) begin
                    if (m_squash) m_squash = 1'b0;
                    else m_buf.push_back(m_infl_pc);
                end
                if (e_req) begin
                    m_infl_pc  = m_fetch_pc;
                    m_fetch_pc = m_fetch_pc + 32'd4;
                end
                m_infl = e_req;
            end
        end
    endtask

    initial begin
        logic [31:0] tgt;
        // Reset release, streaming
        repeat (2) step(1, 0, 0, 0, 1);
        repeat (10) step(0, 0, 0, 0, 1);
        // Backpressure fill then drain
        step(1, 0, 0, 0, 1);
        repeat (6) step(0, 0, 0, 0, 0);
        repeat (6) step(0, 0, 0, 0, 1);
        // Redirect with a full pipeline of old words
        step(1, 0, 0, 0, 1);
        repeat (2) step(0, 0, 0, 0, 0);
        step(0, 1, 32'h0000_2000, 0, 0);
        repeat (6) step(0, 0, 0, 0, 1);
        // Redirect under halt, unaligned target
        step(0, 0, 0, 1, 1);
        step(0, 1, 32'h0000_3003, 1, 1);
        repeat (2) step(0, 0, 0, 1, 1);
        repeat (6) step(0, 0, 0, 0, 1);
        // Back-to-back redirects
        step(0, 1, 32'h0000_0400, 0, 1);
        step(0, 1, 32'h0000_0800, 0, 1);
        repeat (6) step(0, 0, 0, 0, 1);
        // Reset with the buffer full
        repeat (4) step(0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1);
        repeat (6) step(0, 0, 0, 0, 1);
        // PC wrap
        step(0, 1, 32'hFFFF_FFF6, 0, 1);
        repeat (8) step(0, 0, 0, 0, 1);

        for (int i = 0; i < 3000; i++) begin
            tgt = ($urandom_range(0, 9) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                              : $urandom;
            step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 6, tgt,
                 $urandom_range(0, 99) < 20, $urandom_range(0, 99) < 70);
        end

        check_eq("progress", 32'(n_pops > 500), 32'd1);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
